// File: rtl/tap_controller_if.sv
// rtl/tap_controller_if.sv - JTAG pin/scan-control bundle between TAP controller and the chip
interface tap_controller_if #(
  parameter int SEL_W  = 2,
  parameter int NUM_DR = 4
);
  logic              TMS;
  logic              TDI;
  logic [SEL_W-1:0]  sel;
  logic              ir_tdo;
  logic [NUM_DR-1:0] dr_tdo;
  logic              clockdr;
  logic              shiftdr;
  logic              updatedr;
  logic              clockir;
  logic              shiftir;
  logic              updateir;
  logic              bs_en;
  logic              tlr;
  logic              TDO;
  logic              tdo_en;

  modport master (
    output TMS, TDI, sel, ir_tdo, dr_tdo,
    input  clockdr, shiftdr, updatedr, clockir, shiftir, updateir, bs_en, tlr, TDO, tdo_en
  );

  modport slave (
    input  TMS, TDI, sel, ir_tdo, dr_tdo,
    output clockdr, shiftdr, updatedr, clockir, shiftir, updateir, bs_en, tlr, TDO, tdo_en
  );
endinterface

// File: rtl/tap_controller.sv
// rtl/tap_controller.sv - 16-state JTAG TAP controller with BYPASS register and TDO mux
module tap_controller #(
  parameter int               SEL_W       = 2,
  parameter int               NUM_DR      = 4,
  parameter logic [SEL_W-1:0] EXTEST_CODE = '0,
  parameter logic [SEL_W-1:0] BYPASS_CODE = '1
) (
  input logic             TCK,
  input logic             reset,
  tap_controller_if.slave tap
);

  typedef enum logic [3:0] {
    TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
    SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
  } tap_state_e;

  tap_state_e        state_q, state_d;
  logic              clockdr_q, clockdr_d;
  logic              shiftdr_q, shiftdr_d;
  logic              updatedr_q, updatedr_d;
  logic              clockir_q, clockir_d;
  logic              shiftir_q, shiftir_d;
  logic              updateir_q, updateir_d;
  logic              bs_en_q, bs_en_d;
  logic              tlr_q, tlr_d;
  logic              bypass_q, bypass_d;
  logic              tdo_q, tdo_d;
  logic              tdo_en_q, tdo_en_d;
  logic [NUM_DR-1:0] dr_src;
  logic              is_bypass;

  assign dr_src    = tap.dr_tdo;
  assign is_bypass = (tap.sel == BYPASS_CODE);

  always_ff @(posedge TCK or posedge reset) begin
    if (reset) begin
      state_q    <= TLR;
      clockdr_q  <= 1'b0;
      shiftdr_q  <= 1'b0;
      updatedr_q <= 1'b0;
      clockir_q  <= 1'b0;
      shiftir_q  <= 1'b0;
      updateir_q <= 1'b0;
      bs_en_q    <= 1'b0;
      tlr_q      <= 1'b1;
      bypass_q   <= 1'b0;
      tdo_q      <= 1'b0;
      tdo_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      clockdr_q  <= clockdr_d;
      shiftdr_q  <= shiftdr_d;
      updatedr_q <= updatedr_d;
      clockir_q  <= clockir_d;
      shiftir_q  <= shiftir_d;
      updateir_q <= updateir_d;
      bs_en_q    <= bs_en_d;
      tlr_q      <= tlr_d;
      bypass_q   <= bypass_d;
      tdo_q      <= tdo_d;
      tdo_en_q   <= tdo_en_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      TLR:     state_d = tap.TMS ? TLR    : RTI;
      RTI:     state_d = tap.TMS ? SEL_DR : RTI;
      SEL_DR:  state_d = tap.TMS ? SEL_IR : CAP_DR;
      CAP_DR:  state_d = tap.TMS ? EX1_DR : SH_DR;
      SH_DR:   state_d = tap.TMS ? EX1_DR : SH_DR;
      EX1_DR:  state_d = tap.TMS ? UPD_DR : PAU_DR;
      PAU_DR:  state_d = tap.TMS ? EX2_DR : PAU_DR;
      EX2_DR:  state_d = tap.TMS ? UPD_DR : SH_DR;
      UPD_DR:  state_d = tap.TMS ? SEL_DR : RTI;
      SEL_IR:  state_d = tap.TMS ? TLR    : CAP_IR;
      CAP_IR:  state_d = tap.TMS ? EX1_IR : SH_IR;
      SH_IR:   state_d = tap.TMS ? EX1_IR : SH_IR;
      EX1_IR:  state_d = tap.TMS ? UPD_IR : PAU_IR;
      PAU_IR:  state_d = tap.TMS ? EX2_IR : PAU_IR;
      EX2_IR:  state_d = tap.TMS ? UPD_IR : SH_IR;
      UPD_IR:  state_d = tap.TMS ? SEL_DR : RTI;
      default: state_d = TLR;
    endcase
  end

  // Controls decode the next state so the registered copies line up with state_q.
  always_comb begin
    clockdr_d  = (state_d == CAP_DR) || (state_d == SH_DR);
    shiftdr_d  = (state_d == SH_DR);
    updatedr_d = (state_d == UPD_DR);
    clockir_d  = (state_d == CAP_IR) || (state_d == SH_IR);
    shiftir_d  = (state_d == SH_IR);
    updateir_d = (state_d == UPD_IR);
    tlr_d      = (state_d == TLR);
    bs_en_d    = (tap.sel == EXTEST_CODE) && (state_d != TLR);
  end

  always_comb begin
    bypass_d = bypass_q;
    tdo_d    = tdo_q;
    tdo_en_d = 1'b0;
    if (is_bypass && (state_q == CAP_DR)) begin
      bypass_d = 1'b0;
    end else if (is_bypass && (state_q == SH_DR)) begin
      bypass_d = tap.TDI;
    end
    if (state_q == SH_IR) begin
      tdo_d    = tap.ir_tdo;
      tdo_en_d = 1'b1;
    end else if (state_q == SH_DR) begin
      tdo_d    = is_bypass ? bypass_q : dr_src[tap.sel];
      tdo_en_d = 1'b1;
    end
  end

  assign tap.clockdr  = clockdr_q;
  assign tap.shiftdr  = shiftdr_q;
  assign tap.updatedr = updatedr_q;
  assign tap.clockir  = clockir_q;
  assign tap.shiftir  = shiftir_q;
  assign tap.updateir = updateir_q;
  assign tap.bs_en    = bs_en_q;
  assign tap.tlr      = tlr_q;
  assign tap.TDO      = tdo_q;
  assign tap.tdo_en   = tdo_en_q;

endmodule

// File: tb/tb_tap_controller.sv
// tb/tb_tap_controller.sv - directed and random bench for tap_controller against a table-driven model
module tb_tap_controller;
  logic TCK = 1'b0;
  logic reset;

  tap_controller_if #(.SEL_W(2), .NUM_DR(4)) tap ();

  tap_controller #(
    .SEL_W(2), .NUM_DR(4), .EXTEST_CODE(2'b00), .BYPASS_CODE(2'b11)
  ) dut (
    .TCK(TCK), .reset(reset), .tap(tap)
  );

  always #5 TCK = ~TCK;

  localparam int M_TLR = 0, M_RTI = 1, M_SDR = 2, M_SIR = 9;
  localparam int DR_BASE = 3, IR_BASE = 10;
  // Scan-leg offsets from DR_BASE/IR_BASE: capture, shift, exit1, pause, exit2, update
  localparam int O_CAP = 0, O_SH = 1, O_EX1 = 2, O_PAU = 3, O_EX2 = 4, O_UPD = 5;

  int nxt [16][2];
  int m_state;
  bit m_bypass, m_tdo, m_tdo_en, m_bs_en;
  int n_cmp = 0;
  int n_err = 0;
  int cnt_cir, cnt_sir, cnt_uir;

  function automatic logic [9:0] expected_vec();
    logic [9:0] v;
    v[9] = (m_state == DR_BASE + O_CAP) || (m_state == DR_BASE + O_SH);
    v[8] = (m_state == DR_BASE + O_SH);
    v[7] = (m_state == DR_BASE + O_UPD);
    v[6] = (m_state == IR_BASE + O_CAP) || (m_state == IR_BASE + O_SH);
    v[5] = (m_state == IR_BASE + O_SH);
    v[4] = (m_state == IR_BASE + O_UPD);
    v[3] = m_bs_en;
    v[2] = (m_state == M_TLR);
    v[1] = m_tdo;
    v[0] = m_tdo_en;
    return v;
  endfunction

  function automatic logic [9:0] observed_vec();
    return {tap.clockdr, tap.shiftdr, tap.updatedr, tap.clockir, tap.shiftir,
            tap.updateir, tap.bs_en, tap.tlr, tap.TDO, tap.tdo_en};
  endfunction

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    logic [9:0] obs, exp;
    obs = observed_vec();
    exp = expected_vec();
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed={cdr,sdr,udr,cir,sir,uir,bs,tlr,tdo,en}=%b expected=%b state=%0d",
             tag, obs, exp, m_state);
    end
  endtask

  task automatic model_reset();
    m_state  = M_TLR;
    m_bypass = 1'b0;
    m_tdo    = 1'b0;
    m_tdo_en = 1'b0;
    m_bs_en  = 1'b0;
  endtask

  // Applies one rising edge to the model using the inputs currently on the interface.
  task automatic model_edge();
    int  ns;
    bit  old_bypass;
    logic [3:0] dr;
    ns = nxt[m_state][tap.TMS ? 1 : 0];
    old_bypass = m_bypass;
    dr = tap.dr_tdo;
    if (tap.sel == 2'b11 && m_state == DR_BASE + O_CAP) m_bypass = 1'b0;
    if (tap.sel == 2'b11 && m_state == DR_BASE + O_SH)  m_bypass = tap.TDI;
    m_tdo_en = 1'b0;
    if (m_state == IR_BASE + O_SH) begin
      m_tdo = tap.ir_tdo;
      m_tdo_en = 1'b1;
    end else if (m_state == DR_BASE + O_SH) begin
      m_tdo = (tap.sel == 2'b11) ? old_bypass : dr[tap.sel];
      m_tdo_en = 1'b1;
    end
    m_bs_en = (tap.sel == 2'b00) && (ns != M_TLR);
    m_state = ns;
  endtask

  task automatic step(input bit tms, input bit tdi, input logic [1:0] s,
                      input bit ir, input logic [3:0] dr, input string tag);
    tap.TMS = tms;
    tap.TDI = tdi;
    tap.sel = s;
    tap.ir_tdo = ir;
    tap.dr_tdo = dr;
    @(posedge TCK);
    model_edge();
    #1;
    check_model(tag);
  endtask

  // Asynchronous pulse placed mid-cycle, released before the next rising edge.
  task automatic pulse_reset(input string tag);
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    #2 reset = 1'b0;
  endtask

  initial begin
    int base;
    bit seq3 [9];
    seq3 = '{0, 1, 1, 0, 0, 0, 1, 1, 0};

    nxt[M_TLR] = '{1, 0};
    nxt[M_RTI] = '{1, 2};
    nxt[M_SDR] = '{DR_BASE, M_SIR};
    nxt[M_SIR] = '{IR_BASE, M_TLR};
    for (int k = 0; k < 2; k++) begin
      base = (k == 0) ? DR_BASE : IR_BASE;
      nxt[base + O_CAP] = '{base + O_SH,  base + O_EX1};
      nxt[base + O_SH]  = '{base + O_SH,  base + O_EX1};
      nxt[base + O_EX1] = '{base + O_PAU, base + O_UPD};
      nxt[base + O_PAU] = '{base + O_PAU, base + O_EX2};
      nxt[base + O_EX2] = '{base + O_SH,  base + O_UPD};
      nxt[base + O_UPD] = '{M_RTI, M_SDR};
    end

    tap.TMS = 1'b1; tap.TDI = 1'b0; tap.sel = 2'b01; tap.ir_tdo = 1'b0; tap.dr_tdo = 4'b0;
    reset = 1'b1;
    model_reset();
    #12;
    check_model("reset_state");
    @(negedge TCK);
    reset = 1'b0;

    // TLR through an IR scan and back to RTI
    cnt_cir = 0; cnt_sir = 0; cnt_uir = 0;
    for (int i = 0; i < 9; i++) begin
      step(seq3[i], 1'b0, 2'b01, 1'b1, 4'b0, "ir_walk");
      cnt_cir += int'(tap.clockir);
      cnt_sir += int'(tap.shiftir);
      cnt_uir += int'(tap.updateir);
    end
    check_bit("clockir_cycles_3", cnt_cir == 3, 1'b1);
    check_bit("shiftir_cycles_2", cnt_sir == 2, 1'b1);
    check_bit("updateir_cycles_1", cnt_uir == 1, 1'b1);

    // BYPASS DR scan shifting 1,0,1
    step(1, 0, 2'b11, 0, 4'b0, "byp_sel_dr");
    step(0, 0, 2'b11, 0, 4'b0, "byp_cap_dr");
    step(0, 1, 2'b11, 0, 4'b0, "byp_enter_sh");
    step(0, 1, 2'b11, 0, 4'b0, "byp_sh1");
    check_bit("byp_tdo_captured0", tap.TDO, 1'b0);
    check_bit("byp_tdo_en_sh", tap.tdo_en, 1'b1);
    step(0, 0, 2'b11, 0, 4'b0, "byp_sh2");
    check_bit("byp_tdo_1", tap.TDO, 1'b1);
    step(1, 1, 2'b11, 0, 4'b0, "byp_sh3");
    check_bit("byp_tdo_0", tap.TDO, 1'b0);
    step(1, 0, 2'b11, 0, 4'b0, "byp_upd");
    check_bit("byp_tdo_en_off", tap.tdo_en, 1'b0);
    step(0, 0, 2'b11, 0, 4'b0, "byp_rti");

    // EXTEST DR scan through pause loop
    step(1, 0, 2'b00, 0, 4'b1111, "ext_sel_dr");
    step(0, 0, 2'b00, 0, 4'b1111, "ext_cap");
    step(0, 0, 2'b00, 0, 4'b1111, "ext_sh");
    step(1, 0, 2'b00, 0, 4'b1111, "ext_ex1");
    step(0, 0, 2'b00, 0, 4'b1111, "ext_pau");
    check_bit("ext_shiftdr_pause", tap.shiftdr, 1'b0);
    step(0, 0, 2'b00, 0, 4'b1111, "ext_pau2");
    step(1, 0, 2'b00, 0, 4'b1111, "ext_ex2");
    step(0, 0, 2'b00, 0, 4'b1111, "ext_sh_resume");
    check_bit("ext_shiftdr_resume", tap.shiftdr, 1'b1);
    step(1, 0, 2'b00, 0, 4'b1111, "ext_ex1b");
    step(1, 0, 2'b00, 0, 4'b1111, "ext_upd");
    check_bit("ext_updatedr", tap.updatedr, 1'b1);
    step(0, 0, 2'b00, 0, 4'b1111, "ext_rti");
    check_bit("ext_bs_en_held", tap.bs_en, 1'b1);

    // DR source mux then IR shift
    step(1, 0, 2'b01, 1, 4'b0010, "mux_sel_dr");
    step(0, 0, 2'b01, 1, 4'b0010, "mux_cap");
    step(0, 0, 2'b01, 1, 4'b0010, "mux_sh");
    step(0, 0, 2'b01, 1, 4'b0010, "mux_sh1");
    check_bit("mux_dr1_tdo", tap.TDO, 1'b1);
    step(1, 0, 2'b01, 1, 4'b0010, "mux_ex1");
    step(1, 0, 2'b01, 1, 4'b0010, "mux_upd");
    step(1, 0, 2'b01, 1, 4'b0010, "mux_sel_dr2");
    step(1, 0, 2'b01, 1, 4'b0010, "mux_sel_ir");
    step(0, 0, 2'b01, 1, 4'b0010, "mux_cap_ir");
    step(0, 0, 2'b01, 0, 4'b0010, "mux_sh_ir");
    step(0, 0, 2'b01, 0, 4'b0010, "mux_sh_ir1");
    check_bit("mux_ir_tdo0", tap.TDO, 1'b0);

    // Five TMS=1 from SH_IR-adjacent shift leg: tlr only on the fifth
    step(1, 0, 2'b01, 0, 4'b0, "tms5_e1");
    step(1, 0, 2'b01, 0, 4'b0, "tms5_e2");
    step(1, 0, 2'b01, 0, 4'b0, "tms5_e3");
    check_bit("tms5_not_yet", tap.tlr, 1'b0);
    step(1, 0, 2'b01, 0, 4'b0, "tms5_e4");
    step(1, 0, 2'b01, 0, 4'b0, "tms5_e5");
    check_bit("tms5_tlr", tap.tlr, 1'b1);

    // Reset in the middle of a DR shift
    step(0, 0, 2'b00, 0, 4'b0, "rst_rti");
    step(1, 0, 2'b00, 0, 4'b0, "rst_sel_dr");
    step(0, 0, 2'b00, 0, 4'b0, "rst_cap");
    step(0, 0, 2'b00, 0, 4'b1, "rst_sh");
    step(0, 0, 2'b00, 0, 4'b1, "rst_sh1");
    pulse_reset("reset_mid_shift");
    check_bit("reset_mid_tlr", tap.tlr, 1'b1);
    step(0, 0, 2'b00, 0, 4'b0, "after_reset_rti");

    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 99) < 35), bit'($urandom % 2),
           2'($urandom_range(0, 3)), bit'($urandom % 2), 4'($urandom % 16), "random");
      if ($urandom_range(0, 63) == 0) pulse_reset("random_reset");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
